// File: rtl/prefix_adder_pkg.sv
// Shared types and helpers for the pipelined Kogge-Stone adder.
// Generate/propagate pair, black-cell combine and stage placement.
package prefix_adder_pkg;

  localparam int MIN_WIDTH = 8;
  localparam int MAX_WIDTH = 64;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  function automatic gp_t gp_combine(gp_t hi, gp_t lo);
    gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

  function automatic int level_of_stage(int k, int l, int stages);
    return (k * l + stages - 1) / stages;
  endfunction

  // True when a non-output stage register follows prefix level lvl.
  function automatic bit reg_after_level(int lvl, int l, int stages);
    for (int k = 1; k < stages; k++)
      if (level_of_stage(k, l, stages) == lvl)
        return 1'b1;
    return 1'b0;
  endfunction

endpackage

// File: rtl/pipelined_prefix_adder_cell.sv
// One Kogge-Stone black-cell row, optionally registered.
// Side-band bits travel with the row so they stay aligned.
module prefix_gp_cell
  import prefix_adder_pkg::*;
#(
  parameter int N     = 33,
  parameter int SPAN  = 1,
  parameter int REG   = 0,
  parameter int SIDEW = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  gp_t  [N-1:0]         gpIn,
  input  logic [SIDEW-1:0]     sideIn,
  output gp_t  [N-1:0]         gpOut,
  output logic [SIDEW-1:0]     sideOut
);

  gp_t [N-1:0] row;

  always_comb begin
    row = gpIn;
    for (int j = SPAN; j < N; j++)
      row[j] = gp_combine(gpIn[j], gpIn[j-SPAN]);
  end

  if (REG != 0) begin : gReg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        gpOut   <= '0;
        sideOut <= '0;
      end else if (en) begin
        gpOut   <= row;
        sideOut <= sideIn;
      end
    end
  end else begin : gComb
    logic unusedCtl;
    assign unusedCtl = clk ^ rst_n ^ en;
    assign gpOut     = row;
    assign sideOut   = sideIn;
  end

endmodule

// File: rtl/pipelined_prefix_adder.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready stream.
// Define PREFIX_ADDER_SAT_EN to add the sat_en saturating mode.
module pipelined_prefix_adder
  import prefix_adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
`ifdef PREFIX_ADDER_SAT_EN
  input  logic             sat_en,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int L = $clog2(WIDTH);
  localparam int N = WIDTH + 1;
`ifdef PREFIX_ADDER_SAT_EN
  localparam int SW = WIDTH + 2;
  localparam logic [WIDTH-1:0] MAXV =
    {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINV =
    {1'b1, {(WIDTH-1){1'b0}}};
`else
  localparam int SW = WIDTH + 1;
`endif

  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH ||
      (WIDTH & (WIDTH - 1)) != 0) begin : gBadW
    $error("pipelined_prefix_adder: bad WIDTH %0d", WIDTH);
  end
  if (STAGES < 1 || STAGES > L + 1) begin : gBadS
    $error("pipelined_prefix_adder: bad STAGES %0d", STAGES);
  end

  logic             adv;
  logic [WIDTH-1:0] bEff;
  gp_t  [N-1:0]     gp0;
  gp_t  [N-1:0]     rowD  [0:L];
  logic [SW-1:0]    sideD [0:L];

  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;
  assign bEff     = sub ? ~b : b;

  // Entry 0 is the carry-in as g[-1]; entry i+1 is operand bit i.
  always_comb begin
    gp0[0] = '{g: sub | ci, p: 1'b0};
    for (int i = 0; i < WIDTH; i++)
      gp0[i+1] = '{g: a[i] & bEff[i], p: a[i] ^ bEff[i]};
  end

  assign rowD[0] = gp0;
`ifdef PREFIX_ADDER_SAT_EN
  assign sideD[0] = {sat_en, a[WIDTH-1], a ^ bEff};
`else
  assign sideD[0] = {a[WIDTH-1], a ^ bEff};
`endif

  for (genvar l = 1; l <= L; l++) begin : gRow
    prefix_gp_cell #(
      .N    (N),
      .SPAN (1 << (l - 1)),
      .REG  (int'(reg_after_level(l, L, STAGES))),
      .SIDEW(SW)
    ) uRow (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (adv),
      .gpIn   (rowD[l-1]),
      .sideIn (sideD[l-1]),
      .gpOut  (rowD[l]),
      .sideOut(sideD[l])
    );
  end

  logic [STAGES-1:0] vldQ;
  logic              lastIn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vldQ <= '0;
    end else if (adv) begin
      vldQ[0] <= in_valid;
      for (int k = 1; k < STAGES; k++)
        vldQ[k] <= vldQ[k-1];
    end
  end

  if (STAGES == 1) begin : gLast1
    assign lastIn = in_valid;
  end else begin : gLastN
    assign lastIn = vldQ[STAGES-2];
  end

  assign out_valid = vldQ[STAGES-1];

  logic [WIDTH-1:0] sRaw;
  logic [WIDTH-1:0] sNext;
  logic             coNext;
  logic             ovfNext;
  logic             unusedP;

  always_comb begin
    unusedP = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      sRaw[i] = sideD[L][i] ^ rowD[L][i].g;
      unusedP = unusedP ^ rowD[L][i].p;
    end
    coNext = rowD[L][WIDTH].g |
             (rowD[L][WIDTH].p & rowD[L][0].g);
    // b' MSB equals a' MSB exactly when the MSB propagate is 0.
    ovfNext = !sideD[L][WIDTH-1] &
              (sRaw[WIDTH-1] ^ sideD[L][WIDTH]);
    sNext = sRaw;
`ifdef PREFIX_ADDER_SAT_EN
    if (sideD[L][WIDTH+1] && ovfNext)
      sNext = sideD[L][WIDTH] ? MINV : MAXV;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s   <= '0;
      co  <= 1'b0;
      ovf <= 1'b0;
    end else if (adv && lastIn) begin
      s   <= sNext;
      co  <= coNext;
      ovf <= ovfNext;
    end
  end

endmodule

// File: doc/pipelined_prefix_adder.md
Name: pipelined_prefix_adder

Overview:
Parametrised, pipelined Kogge-Stone parallel-prefix adder/subtractor with a valid/ready stream interface. It is the next generation of the team's combinational prefix adder. Width is any power of two from 8 to 64, and the register-stage count is selectable. Supports add/subtract per transaction, backpressure, and signed-overflow reporting. It sits in datapaths that need a >1 GHz add slice.

Parameters:
WIDTH, 32, operand/result width; power of two, 8..64
STAGES, 2, register stages from input acceptance to output; 1..log2(WIDTH)+1

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept operand beat
a  input  WIDTH  operand A
b  input  WIDTH  operand B
ci  input  1  carry-in; ignored when sub=1 (forced to 1)
sub  input  1  1: compute a - b (a + ~b + 1)
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts result
s  output  WIDTH  sum/difference
co  output  1  carry-out of MSB (for sub: 1 = no borrow)
ovf  output  1  signed overflow: (a'[MSB]==b'[MSB]) && (s[MSB]!=a'[MSB]), where b' = sub ? ~b : b

Behaviour:
- Reset: out_valid=0, s=0, co=0, ovf=0, all internal stage-valid bits=0. Reset is asynchronous and applied at any time; in-flight beats are discarded without output.
- Datapath levels: level 0 is the bitwise p/g generation with ci folded in as g[-1]; levels 1..L (L = log2 WIDTH) are Kogge-Stone black cells at span 2^(l-1); the final level computes s = p XOR carry.
- Register placement: stage k (1..STAGES) register follows prefix level ceil(k*L/STAGES), evaluated over levels 0..L. The stage-STAGES register is always the output register holding s/co/ovf.
- Latency: exactly STAGES cycles from an accepted beat (in_valid & in_ready) to out_valid, absent backpressure. Throughput is 1 beat/cycle.
- Flow control: global stall. in_ready = !out_valid | out_ready, combinational from out_ready only. When the pipeline is not advancing, every stage holds its data and valid bit.
- Bubbles: stage valid bits propagate independently. Data registers of invalid stages may load anything. s/co/ovf change only on an advancing cycle that loads a valid beat, and hold otherwise.
- Output hold: while out_valid=1 and out_ready=0, s/co/ovf stay stable.
- Simultaneous accept and output drain in the same cycle is legal, with no bubble inserted.
- Input data is sampled only when in_valid & in_ready. a/b/ci/sub are don't-care otherwise.
- Subtract: b' = ~b, effective carry-in = 1, and the ci pin is ignored.
- Wrap-around: results are modulo 2^WIDTH; co and ovf report the carry-out and signed overflow.
- Illegal WIDTH/STAGES values cause an elaboration-time $error.

Optional Feature:
- PREFIX_ADDER_SAT_EN defined: adds port sat_en (input, 1, sampled with operands). When sat_en=1 and ovf=1, s is clamped to the signed max (0111..1) if a'[MSB]=0, otherwise to the signed min (1000..0). ovf still reports 1. Clamping is applied in the output stage and adds no latency.
- Macro undefined: the sat_en port is absent and s is always the raw modulo result.

Decomposition:
- Package prefix_adder_pkg:
  - typedef gp_t: struct with fields g and p;
  - function gp_combine(hi, lo): returns g = hi.g | hi.p & lo.g, p = hi.p & lo.p;
  - function level_of_stage(k, L, STAGES);
  - localparam MIN_WIDTH=8, MAX_WIDTH=64.
- Sub-module prefix_gp_cell: one registered-or-combinational black cell row slice, with parameter REG (0/1) and an enable for stall.
- The top module generates L rows of cells, the stage valid chain, and the sum/flag output stage.

Test Plan:
- WIDTH=32, STAGES=2, out_ready=1, a=0xFFFFFFFF, b=1, ci=0, sub=0: after 2 cycles s=0, co=1, ovf=0, out_valid pulses once.
- WIDTH=32, sub=1, a=5, b=7: s=0xFFFFFFFE, co=0, ovf=0. Then a=0x80000000, b=1, sub=1: s=0x7FFFFFFF, ovf=1, co=1.
- WIDTH=8, STAGES=4, 4 back-to-back beats (1+1, 2+2, 0x7F+1, 0xFF+0xFF with ci=1), with out_ready held 0 for 3 cycles after the first output:
  - in_ready drops while out_ready=0;
  - results arrive in order, unchanged during the stall: 0x02; 0x04; 0x80 with ovf=1; 0xFF with co=1.
- WIDTH=64, STAGES=7: random 10k beats with random in_valid/out_ready toggling; every result matches the a+b+ci or a-b reference model, with no drop or duplication.
- Assert rst_n low with 3 beats in flight, then release: out_valid=0 and s=0 immediately, no stale beat emerges afterwards, and the next beat has latency STAGES.
- PREFIX_ADDER_SAT_EN defined, WIDTH=16, sat_en=1: 0x7FFF+1 gives s=0x7FFF, ovf=1; 0x8000-1 (sub) gives s=0x8000, ovf=1.
